// File: rtl/address_calculator_queue.sv
// address_calculator_queue
// Load/store address stage with a DEPTH-entry FIFO in front of the ROB/LSQ
// port. Each accepted dispatch is turned into an effective address plus a
// natural-alignment flag and queued; the head entry drives execute_* directly.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. dispatch_ready depends combinationally on execute_ready, so a full
// queue can take a new entry in the same cycle its head is popped.
// Nothing on dispatch_* reaches execute_* without passing through the queue.
module address_calculator_queue #(
  parameter int XLEN            = 64,
  parameter int ROB_INDEX_WIDTH = 8,
  parameter int DEPTH           = 4,
  parameter int CHECK_ALIGN     = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       dispatch_ready,
  input  logic                       dispatch_valid,
  input  logic [XLEN-1:0]            dispatch_1st_reg,
  input  logic [XLEN-1:0]            dispatch_2nd_reg,
  input  logic [XLEN-1:0]            dispatch_address,
  input  logic [ROB_INDEX_WIDTH-1:0] dispatch_ROB_index,
  input  logic [1:0]                 dispatch_size,
  input  logic                       execute_ready,
  output logic                       execute_valid,
  output logic [ROB_INDEX_WIDTH-1:0] execute_ROB_index,
  output logic [XLEN-1:0]            execute_value,
  output logic [XLEN-1:0]            execute_address,
  output logic [1:0]                 execute_size,
  output logic                       execute_misaligned,
  output logic [$clog2(DEPTH):0]     occupancy,
  input  logic                       flush
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [ROB_INDEX_WIDTH-1:0] rob;
    logic [XLEN-1:0]            value;
    logic [XLEN-1:0]            address;
    logic [1:0]                 size;
    logic                       misaligned;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic [XLEN-1:0]    new_address;
  logic               new_misaligned;
  entry_t             new_entry;
  entry_t             head;
  logic               push;
  logic               pop;

  // Effective address and alignment check for the entry being dispatched.
  always_comb begin
    new_address    = dispatch_1st_reg + dispatch_address;
    new_misaligned = 1'b0;
    if (CHECK_ALIGN != 0) begin
      case (dispatch_size)
        2'd0:    new_misaligned = 1'b0;
        2'd1:    new_misaligned = new_address[0];
        2'd2:    new_misaligned = |new_address[1:0];
        default: new_misaligned = |new_address[2:0];
      endcase
    end
    // A doubleword access cannot be performed on a 32-bit machine at all,
    // so it is flagged regardless of whether alignment checking is enabled.
    if ((XLEN == 32) && (dispatch_size == 2'd3)) begin
      new_misaligned = 1'b1;
    end
    new_entry.rob        = dispatch_ROB_index;
    new_entry.value      = dispatch_2nd_reg;
    new_entry.address    = new_address;
    new_entry.size       = dispatch_size;
    new_entry.misaligned = new_misaligned;
  end

  // Handshake: flush wins over both push and pop.
  assign execute_valid  = (occ_q != '0);
  assign dispatch_ready = (occ_q < DEPTH_OCC) || (execute_valid && execute_ready);
  assign pop            = execute_valid && execute_ready && !flush;
  assign push           = dispatch_valid && dispatch_ready && !flush;

  // Next-state for pointers, occupancy and the entry written this cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      // Entry contents are left in place; only the bookkeeping is cleared.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!push && pop) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  // State registers; asynchronous reset also wipes the storage so every
  // output reads 0 while reset is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Head of the queue drives the execute port with no output register.
  assign head               = mem_q[rd_ptr_q];
  assign execute_ROB_index  = head.rob;
  assign execute_value      = head.value;
  assign execute_address    = head.address;
  assign execute_size       = head.size;
  assign execute_misaligned = head.misaligned;
  assign occupancy          = occ_q;

endmodule

// File: tb/tb_address_calculator_queue.sv
// Bench for address_calculator_queue: three instances (default, no alignment
// check, 32-bit) share one stimulus stream and are compared every cycle
// against a queue-based reference model.
module tb_address_calculator_queue;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus ----------------
  logic        dispatch_valid = 1'b0;
  logic [63:0] dispatch_1st_reg = '0;
  logic [63:0] dispatch_2nd_reg = '0;
  logic [63:0] dispatch_address = '0;
  logic [7:0]  dispatch_rob = '0;
  logic [1:0]  dispatch_size = '0;
  logic        execute_ready = 1'b0;
  logic        flush = 1'b0;

  // ---------------- DUT outputs ----------------
  logic        dispatch_ready, execute_valid, execute_misaligned;
  logic [7:0]  execute_rob;
  logic [63:0] execute_value, execute_address;
  logic [1:0]  execute_size;
  logic [2:0]  occupancy;

  logic        dr_na, ev_na, mis_na;
  logic [7:0]  rob_na;
  logic [63:0] val_na, addr_na;
  logic [1:0]  size_na;
  logic [2:0]  occ_na;

  logic        dr_32, ev_32, mis_32;
  logic [7:0]  rob_32;
  logic [31:0] val_32, addr_32;
  logic [1:0]  size_32;
  logic [2:0]  occ_32;

  address_calculator_queue #(.XLEN(64), .ROB_INDEX_WIDTH(8), .DEPTH(DEPTH), .CHECK_ALIGN(1)) dut (
    .clock(clock), .reset(reset),
    .dispatch_ready(dispatch_ready), .dispatch_valid(dispatch_valid),
    .dispatch_1st_reg(dispatch_1st_reg), .dispatch_2nd_reg(dispatch_2nd_reg),
    .dispatch_address(dispatch_address), .dispatch_ROB_index(dispatch_rob),
    .dispatch_size(dispatch_size), .execute_ready(execute_ready),
    .execute_valid(execute_valid), .execute_ROB_index(execute_rob),
    .execute_value(execute_value), .execute_address(execute_address),
    .execute_size(execute_size), .execute_misaligned(execute_misaligned),
    .occupancy(occupancy), .flush(flush)
  );

  address_calculator_queue #(.XLEN(64), .ROB_INDEX_WIDTH(8), .DEPTH(DEPTH), .CHECK_ALIGN(0)) dut_na (
    .clock(clock), .reset(reset),
    .dispatch_ready(dr_na), .dispatch_valid(dispatch_valid),
    .dispatch_1st_reg(dispatch_1st_reg), .dispatch_2nd_reg(dispatch_2nd_reg),
    .dispatch_address(dispatch_address), .dispatch_ROB_index(dispatch_rob),
    .dispatch_size(dispatch_size), .execute_ready(execute_ready),
    .execute_valid(ev_na), .execute_ROB_index(rob_na),
    .execute_value(val_na), .execute_address(addr_na),
    .execute_size(size_na), .execute_misaligned(mis_na),
    .occupancy(occ_na), .flush(flush)
  );

  address_calculator_queue #(.XLEN(32), .ROB_INDEX_WIDTH(8), .DEPTH(DEPTH), .CHECK_ALIGN(1)) dut_32 (
    .clock(clock), .reset(reset),
    .dispatch_ready(dr_32), .dispatch_valid(dispatch_valid),
    .dispatch_1st_reg(dispatch_1st_reg[31:0]), .dispatch_2nd_reg(dispatch_2nd_reg[31:0]),
    .dispatch_address(dispatch_address[31:0]), .dispatch_ROB_index(dispatch_rob),
    .dispatch_size(dispatch_size), .execute_ready(execute_ready),
    .execute_valid(ev_32), .execute_ROB_index(rob_32),
    .execute_value(val_32), .execute_address(addr_32),
    .execute_size(size_32), .execute_misaligned(mis_32),
    .occupancy(occ_32), .flush(flush)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0]  rob;
    logic [63:0] value;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        mis;
    logic [31:0] addr32;
    logic        mis32;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pop_log[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: effective address and natural-alignment rule in plain arithmetic.
  function automatic exp_t make_exp();
    exp_t        e;
    logic [63:0] mask;
    mask     = (64'd1 << dispatch_size) - 64'd1;
    e.rob    = dispatch_rob;
    e.value  = dispatch_2nd_reg;
    e.size   = dispatch_size;
    e.addr   = dispatch_1st_reg + dispatch_address;
    e.mis    = (e.addr & mask) != 64'd0;
    e.addr32 = dispatch_1st_reg[31:0] + dispatch_address[31:0];
    e.mis32  = (dispatch_size == 2'd3) ? 1'b1 : ((e.addr32 & mask[31:0]) != 32'd0);
    return e;
  endfunction

  task automatic check_outputs();
    logic exp_valid, exp_ready;
    exp_valid = exp_q.size() != 0;
    exp_ready = (exp_q.size() < DEPTH) || (exp_valid && execute_ready);
    check("dispatch_ready", 64'(dispatch_ready), 64'(exp_ready));
    check("execute_valid", 64'(execute_valid), 64'(exp_valid));
    check("occupancy", 64'(occupancy), 64'(exp_q.size()));
    check("valid_32", 64'(ev_32), 64'(exp_valid));
    check("ready_na", 64'(dr_na), 64'(exp_ready));
    if (exp_valid) begin
      check("rob", 64'(execute_rob), 64'(exp_q[0].rob));
      check("value", execute_value, exp_q[0].value);
      check("address", execute_address, exp_q[0].addr);
      check("size", 64'(execute_size), 64'(exp_q[0].size));
      check("misaligned", 64'(execute_misaligned), 64'(exp_q[0].mis));
      check("misaligned_na", 64'(mis_na), 64'd0);
      check("address_na", addr_na, exp_q[0].addr);
      check("address_32", 64'(addr_32), 64'(exp_q[0].addr32));
      check("value_32", 64'(val_32), 64'(exp_q[0].value[31:0]));
      check("misaligned_32", 64'(mis_32), 64'(exp_q[0].mis32));
    end
  endtask

  // One clock: check at negedge, advance the model, return at posedge+1.
  task automatic step();
    logic exp_ready, exp_pop;
    @(negedge clock);
    check_outputs();
    exp_pop   = (exp_q.size() != 0) && execute_ready;
    exp_ready = (exp_q.size() < DEPTH) || exp_pop;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (exp_pop) begin
        pop_log.push_back(execute_rob);
        void'(exp_q.pop_front());
      end
      if (dispatch_valid && exp_ready) exp_q.push_back(make_exp());
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [63:0] base, input logic [63:0] data,
                       input logic [63:0] imm, input logic [7:0] rob, input logic [1:0] size);
    dispatch_valid   = v;
    dispatch_1st_reg = base;
    dispatch_2nd_reg = data;
    dispatch_address = imm;
    dispatch_rob     = rob;
    dispatch_size    = size;
  endtask

  task automatic drive_random(input logic v, input logic [7:0] rob);
    logic [63:0] base, imm;
    base = {$urandom, $urandom};
    imm  = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
    drive(v, base, {$urandom, $urandom}, imm, rob, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Reset state while held low.
    #12;
    check("rst_ready", 64'(dispatch_ready), 64'd1);
    check("rst_valid", 64'(execute_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_address", execute_address, 64'd0);
    check("rst_rob", 64'(execute_rob), 64'd0);
    @(posedge clock);
    #2 reset = 1'b1;

    // Basic: 0x1000 + (-8), doubleword.
    execute_ready = 1'b1;
    drive(1'b1, 64'h1000, 64'hAB, 64'hFFFF_FFFF_FFFF_FFF8, 8'd5, 2'd3);
    step();
    dispatch_valid = 1'b0;
    check("basic_valid", 64'(execute_valid), 64'd1);
    check("basic_address", execute_address, 64'hFF8);
    check("basic_mis", 64'(execute_misaligned), 64'd0);
    check("basic_rob", 64'(execute_rob), 64'd5);
    check("basic_value", execute_value, 64'hAB);
    step();
    check("basic_occ_after", 64'(occupancy), 64'd0);

    // Alignment at base 0x1001 for each size.
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 64'h1001, 64'(s), 64'd0, 8'(10 + s), 2'(s));
      step();
      check("align_mis", 64'(execute_misaligned), (s == 0) ? 64'd0 : 64'd1);
      check("align_mis_na", 64'(mis_na), 64'd0);
    end
    // Aligned doubleword on the 32-bit instance is still flagged.
    drive(1'b1, 64'h1000, 64'h55, 64'd0, 8'd20, 2'd3);
    step();
    dispatch_valid = 1'b0;
    check("align32_mis", 64'(mis_32), 64'd1);
    check("align64_mis", 64'(execute_misaligned), 64'd0);
    step();
    step();

    // Fill with ROB 1..4, then hold full.
    pop_log.delete();
    execute_ready = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      drive_random(1'b1, 8'(r));
      step();
    end
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_ready", 64'(dispatch_ready), 64'd0);
    drive_random(1'b1, 8'd99);
    step();
    step();
    // Push ROB 5..8 while popping; ready must open when full.
    execute_ready = 1'b1;
    for (int r = 5; r <= 8; r++) begin
      drive_random(1'b1, 8'(r));
      #1;
      check("wrap_ready", 64'(dispatch_ready), 64'd1);
      step();
      check("wrap_occ", 64'(occupancy), 64'd4);
    end
    dispatch_valid = 1'b0;
    repeat (5) step();
    check("wrap_count", 64'(pop_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
      check("wrap_order", 64'(pop_log[i]), 64'(i + 1));
    end

    // Flush with 3 held, racing a push and a pop.
    execute_ready = 1'b0;
    for (int r = 30; r < 33; r++) begin
      drive_random(1'b1, 8'(r));
      step();
    end
    drive_random(1'b1, 8'd40);
    execute_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_valid", 64'(execute_valid), 64'd0);
    repeat (2) step();

    // Asynchronous reset with 2 entries held.
    execute_ready = 1'b0;
    for (int r = 50; r < 52; r++) begin
      drive_random(1'b1, 8'(r));
      step();
    end
    dispatch_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("areset_valid", 64'(execute_valid), 64'd0);
    check("areset_occ", 64'(occupancy), 64'd0);
    check("areset_address", execute_address, 64'd0);
    check("areset_ready", 64'(dispatch_ready), 64'd1);
    exp_q.delete();
    @(posedge clock);
    #2 reset = 1'b1;
    drive(1'b1, 64'h2000, 64'h77, 64'h10, 8'd60, 2'd2);
    step();
    dispatch_valid = 1'b0;
    check("post_reset_rob", 64'(execute_rob), 64'd60);
    check("post_reset_address", execute_address, 64'h2010);
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive_random(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      execute_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;
    dispatch_valid = 1'b0;
    execute_ready = 1'b1;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_calculator_queue.md
# address_calculator_queue

Parametrised successor to the single-slot load/store address stage. It receives a base register, a store-data register, an immediate and an access size from the memory reservation station. It computes the effective address and checks natural alignment, then buffers up to DEPTH results in a FIFO in front of the ROB/LSQ port. The added buffering lets the reservation station keep issuing while the downstream port is stalled.

## Interface
Parameters:
- XLEN, 64, operand/address width (32 or 64)
- ROB_INDEX_WIDTH, 8, ROB index bits
- DEPTH, 4, FIFO entries; power of two, >= 2
- CHECK_ALIGN, 1, 1 = compute misalignment flag, 0 = flag tied to 0

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- dispatch_ready  output  1  FIFO can accept this cycle
- dispatch_valid  input  1  dispatch entry presented
- dispatch_1st_reg  input  XLEN  base register
- dispatch_2nd_reg  input  XLEN  store data, passed through
- dispatch_address  input  XLEN  sign-extended immediate
- dispatch_ROB_index  input  ROB_INDEX_WIDTH  destination ROB slot
- dispatch_size  input  2  0=byte, 1=half, 2=word, 3=double
- execute_ready  input  1  downstream accepts head
- execute_valid  output  1  head entry valid
- execute_ROB_index  output  ROB_INDEX_WIDTH  head ROB slot
- execute_value  output  XLEN  head store data
- execute_address  output  XLEN  head effective address
- execute_size  output  2  head access size
- execute_misaligned  output  1  head address not naturally aligned
- occupancy  output  $clog2(DEPTH)+1  entries currently held
- flush  input  1  synchronous clear from ROB

## Operation
- Accept: a dispatch is accepted when dispatch_valid && dispatch_ready at a rising edge.
- Accepted data is written to the entry at the write pointer.
- Address: dispatch_1st_reg + dispatch_address, modulo 2^XLEN; carry is discarded.
- Misaligned: (address & ((1<<size)-1)) != 0 when CHECK_ALIGN=1.
- Size 3 with XLEN=32 always sets misaligned=1. This applies even when CHECK_ALIGN=0.
- Pop: the head entry is removed when execute_valid && execute_ready.
- Outputs: all execute_* outputs are driven from the entry at the read pointer, with no extra register stage.
- Pointers: the read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- Occupancy update: occupancy += push - pop.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- dispatch_ready = (occupancy < DEPTH) || (execute_valid && execute_ready). This allows a push into a full FIFO in the same cycle a pop occurs.
- execute_valid = (occupancy != 0).
- Empty: a push does not bypass the FIFO; the entry appears on the execute port the next cycle.
- Flush (synchronous) has priority over push and pop. It does the following:
  - clears occupancy and both pointers;
  - drops a dispatch presented in the same cycle;
  - does not consume a pop presented in the same cycle.
- Entry contents are not cleared by flush.
- Reset (asynchronous, while low) clears the following:
  - occupancy, both pointers and all entry storage to 0;
  - therefore all outputs to 0, except dispatch_ready = 1.
- Reset asserted mid-operation discards every buffered entry immediately, without waiting for a clock edge.

## Timing
- Latency: an entry accepted at edge N is visible on execute_* after edge N; execute_valid is 1 in cycle N+1.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Combinational paths:
  - execute_ready to dispatch_ready is the only combinational input-to-output path.
  - No path exists from dispatch_* to execute_*.
- Full: with DEPTH entries held and execute_ready=0, dispatch_ready=0, and the held contents and outputs remain stable.
- Reset release: the first accept is possible at the first rising edge after reset goes high.

## Test plan
- Basic: base=0x1000, imm=0xFFFFFFFFFFFFFFF8 (-8), size=3, ROB=5, value=0xAB, with execute_ready=1.
  - One cycle later: execute_valid=1, address=0xFF8, misaligned=0, ROB=5, value=0xAB.
  - The next cycle: occupancy returns to 0.
- Alignment: base=0x1001, imm=0, sizes 0/1/2/3 in turn -> misaligned=0/1/1/1.
  - Same sequence with CHECK_ALIGN=0 -> all 0.
  - XLEN=32 with size=3 and an aligned address -> misaligned=1.
- Fill/wrap: execute_ready=0 and push DEPTH=4 entries with ROB 1..4 -> occupancy=4, dispatch_ready=0.
  - Then raise execute_ready and push ROB 5..8 continuously.
  - The output order must be exactly 1..8, with occupancy held at 4 while push and pop overlap.
- Full push/pop: with the FIFO full, execute_ready=1 and dispatch_valid=1 in the same cycle -> dispatch_ready=1.
  - Occupancy stays 4 and the new entry lands after the existing three.
- Flush: with 3 entries held, assert flush together with dispatch_valid=1 and execute_ready=1.
  - Next cycle: occupancy=0, execute_valid=0; the dropped dispatch never appears.
- Async reset: drive reset low between clock edges with 2 entries held.
  - Before the next edge: execute_valid=0, occupancy=0, execute_address=0, dispatch_ready=1.
  - After release: the first push appears with the correct data.
